uart_cmd_asm: RTL and testbench

- Downstream consumer of the UART receiver.
- Accepts bytes through the receiver's rx_rdy/rx_data/clr_rx_rdy handshake and assembles them into 16-bit commands, high byte first.
- Presents each command to the follower control logic with a cmd_rdy/clr_cmd_rdy handshake.
- An inter-byte timeout resynchronises framing after a dropped byte.

---
 rtl/uart_cmd_asm.sv | 137 +++++++++++++
 tb/tb_uart_cmd_asm.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_cmd_asm.sv
// Assembles UART receiver bytes into 16-bit commands (high byte first) with an inter-byte timeout.
// Optional macro CMD_CHECKSUM_EN adds a third checksum byte and a chk_err output.
module uart_cmd_asm #(
  parameter int TIMEOUT_CYC = 65535,
  parameter int TMO_W       = 16
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rx_rdy,
  input  logic [7:0]  rx_data,
  output logic        clr_rx_rdy,
  output logic [15:0] cmd,
  output logic        cmd_rdy,
  input  logic        clr_cmd_rdy,
  output logic        overrun,
  output logic        tmo_err
`ifdef CMD_CHECKSUM_EN
  ,
  output logic        chk_err
`endif
);

  typedef enum logic [1:0] {IDLE, WAIT_LO, WAIT_CHK} state_t;

  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYC - 1);

  state_t           state_reg, state_next;
  logic             rx_rdy_q;
  logic [7:0]       hi_reg;
  logic [7:0]       lo_byte;
  logic [TMO_W-1:0] cnt_reg, cnt_next;
  logic             accept;
  logic             complete;
  logic             tmo_fire;
  logic             chk_fail;

  // Only the rising edge of the level-style rx_rdy counts as a new byte.
  assign accept = rx_rdy & ~rx_rdy_q;

`ifdef CMD_CHECKSUM_EN
  logic [7:0] lo_reg;
  logic [7:0] chk_sum;
  assign lo_byte = lo_reg;
  assign chk_sum = hi_reg + lo_reg;
`else
  assign lo_byte = rx_data;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    complete   = 1'b0;
    tmo_fire   = 1'b0;
    chk_fail   = 1'b0;
    case (state_reg)
      IDLE: begin
        if (accept) state_next = WAIT_LO;
      end
      WAIT_LO: begin
        // Acceptance is tested first so a byte on the expiry cycle still completes.
        if (accept) begin
`ifdef CMD_CHECKSUM_EN
          state_next = WAIT_CHK;
`else
          complete   = 1'b1;
          state_next = IDLE;
`endif
        end else if (cnt_reg == TMO_LAST) begin
          tmo_fire   = 1'b1;
          state_next = IDLE;
        end
      end
`ifdef CMD_CHECKSUM_EN
      WAIT_CHK: begin
        if (accept) begin
          if (rx_data == chk_sum) complete = 1'b1;
          else                    chk_fail = 1'b1;
          state_next = IDLE;
        end else if (cnt_reg == TMO_LAST) begin
          tmo_fire   = 1'b1;
          state_next = IDLE;
        end
      end
`endif
      default: state_next = IDLE;
    endcase
  end

  // Counter restarts on every accepted byte so each byte gets a full window.
  always_comb begin
    if (state_reg == IDLE || accept || tmo_fire) cnt_next = '0;
    else                                         cnt_next = cnt_reg + TMO_W'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rx_rdy_q   <= 1'b0;
      clr_rx_rdy <= 1'b0;
      tmo_err    <= 1'b0;
      cnt_reg    <= '0;
      hi_reg     <= 8'h00;
      cmd        <= 16'h0000;
      cmd_rdy    <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      rx_rdy_q   <= rx_rdy;
      clr_rx_rdy <= accept;
      tmo_err    <= tmo_fire;
      cnt_reg    <= cnt_next;
      if (accept && state_reg == IDLE) hi_reg <= rx_data;
      if (complete) begin
        cmd     <= {hi_reg, lo_byte};
        cmd_rdy <= 1'b1;
        if (cmd_rdy && !clr_cmd_rdy) overrun <= 1'b1;
      end else if (clr_cmd_rdy) begin
        cmd_rdy <= 1'b0;
      end
    end
  end

`ifdef CMD_CHECKSUM_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lo_reg  <= 8'h00;
      chk_err <= 1'b0;
    end else begin
      chk_err <= chk_fail;
      if (accept && state_reg == WAIT_LO) lo_reg <= rx_data;
    end
  end
`endif

endmodule

// File: tb/tb_uart_cmd_asm.sv
// Self-checking bench for uart_cmd_asm: vector table, directed timeout/reset sequences,
// and a randomized run compared against a byte-queue reference model.
module tb_uart_cmd_asm;

  localparam int TB_TMO = 20;
`ifdef CMD_CHECKSUM_EN
  localparam int NB = 3;
`else
  localparam int NB = 2;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        rx_rdy = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        clr_rx_rdy;
  logic [15:0] cmd;
  logic        cmd_rdy;
  logic        clr_cmd_rdy = 1'b0;
  logic        overrun;
  logic        tmo_err;
`ifdef CMD_CHECKSUM_EN
  logic        chk_err;
`endif

  int total = 0;
  int bad   = 0;

  uart_cmd_asm #(.TIMEOUT_CYC(TB_TMO), .TMO_W(8)) dut (
    .clk(clk),
    .rst(rst),
    .rx_rdy(rx_rdy),
    .rx_data(rx_data),
    .clr_rx_rdy(clr_rx_rdy),
    .cmd(cmd),
    .cmd_rdy(cmd_rdy),
    .clr_cmd_rdy(clr_cmd_rdy),
    .overrun(overrun),
    .tmo_err(tmo_err)
`ifdef CMD_CHECKSUM_EN
    ,
    .chk_err(chk_err)
`endif
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "watchdog");
  end

  // Reference model: bytes collected so far, and idle cycles since the last one.
  logic       m_prev = 1'b0;
  logic [7:0] m_bytes[$];
  int         m_idle = 0;
  logic [15:0] m_cmd = 16'h0000;
  logic       m_rdy = 1'b0, m_ovr = 1'b0, m_tmo = 1'b0, m_clr_rx = 1'b0, m_chk = 1'b0, m_done = 1'b0;

  task automatic model_reset();
    m_prev = 1'b0; m_bytes.delete(); m_idle = 0; m_cmd = 16'h0000;
    m_rdy = 1'b0; m_ovr = 1'b0; m_tmo = 1'b0; m_clr_rx = 1'b0; m_chk = 1'b0; m_done = 1'b0;
  endtask

  task automatic model_step(input logic r, input logic [7:0] d, input logic c);
    logic        acc;
    logic [7:0]  sum;
    logic [15:0] newcmd;
    acc = r && !m_prev;
    m_prev = r; m_clr_rx = acc; m_tmo = 1'b0; m_chk = 1'b0; m_done = 1'b0;
    newcmd = 16'h0000;
    if (acc) begin
      m_bytes.push_back(d);
      m_idle = 0;
      if (m_bytes.size() == NB) begin
        sum = m_bytes[0] + m_bytes[1];
        if (NB == 3 && m_bytes[NB-1] != sum) m_chk = 1'b1;
        else begin
          m_done = 1'b1;
          newcmd = {m_bytes[0], m_bytes[1]};
        end
        m_bytes.delete();
      end
    end else if (m_bytes.size() > 0) begin
      m_idle++;
      if (m_idle >= TB_TMO) begin
        m_bytes.delete();
        m_tmo = 1'b1;
      end
    end
    if (m_done) begin
      if (m_rdy && !c) m_ovr = 1'b1;
      m_rdy = 1'b1;
      m_cmd = newcmd;
    end else if (c) begin
      m_rdy = 1'b0;
    end
  endtask

  task automatic check_b(input string name, input logic act, input logic exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic check_w(input string name, input logic [15:0] act, input logic [15:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cmp_model(input string tag);
    check_b({tag, ".clr_rx_rdy"}, clr_rx_rdy, m_clr_rx);
    check_w({tag, ".cmd"}, cmd, m_cmd);
    check_b({tag, ".cmd_rdy"}, cmd_rdy, m_rdy);
    check_b({tag, ".overrun"}, overrun, m_ovr);
    check_b({tag, ".tmo_err"}, tmo_err, m_tmo);
`ifdef CMD_CHECKSUM_EN
    check_b({tag, ".chk_err"}, chk_err, m_chk);
`endif
  endtask

  task automatic check_zero(input string tag);
    check_b({tag, ".clr_rx_rdy"}, clr_rx_rdy, 1'b0);
    check_w({tag, ".cmd"}, cmd, 16'h0000);
    check_b({tag, ".cmd_rdy"}, cmd_rdy, 1'b0);
    check_b({tag, ".overrun"}, overrun, 1'b0);
    check_b({tag, ".tmo_err"}, tmo_err, 1'b0);
  endtask

  // Drive inputs, clock one edge, advance the model, settle before sampling.
  task automatic step(input logic r, input logic [7:0] d, input logic c);
    rx_rdy = r; rx_data = d; clr_cmd_rdy = c;
    @(posedge clk);
    model_step(r, d, c);
    #1;
  endtask

  typedef struct packed {
    logic        rdy;
    logic [7:0]  data;
    logic        clr;
    logic        e_clr_rx;
    logic        e_rdy;
    logic [15:0] e_cmd;
    logic        e_ovr;
  } vec_t;

  vec_t vecs[$];

  initial begin
    vecs.push_back('{1'b1, 8'hA5, 1'b0, 1'b1, 1'b0, 16'h0000, 1'b0});
    for (int i = 0; i < 4; i++) vecs.push_back('{1'b1, 8'hA5, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0});
    vecs.push_back('{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 16'h0000, 1'b0});
    vecs.push_back('{1'b1, 8'h3C, 1'b0, 1'b1, 1'b1, 16'hA53C, 1'b0});
    for (int i = 0; i < 4; i++) vecs.push_back('{1'b1, 8'h3C, 1'b0, 1'b0, 1'b1, 16'hA53C, 1'b0});
    vecs.push_back('{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 16'hA53C, 1'b0});
    vecs.push_back('{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 16'hA53C, 1'b0});
    vecs.push_back('{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 16'hA53C, 1'b0});
    vecs.push_back('{1'b1, 8'h01, 1'b0, 1'b1, 1'b0, 16'hA53C, 1'b0});
    vecs.push_back('{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 16'hA53C, 1'b0});
    vecs.push_back('{1'b1, 8'h02, 1'b0, 1'b1, 1'b1, 16'h0102, 1'b0});
    vecs.push_back('{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 16'h0102, 1'b0});
    vecs.push_back('{1'b1, 8'h03, 1'b0, 1'b1, 1'b1, 16'h0102, 1'b0});
    vecs.push_back('{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 16'h0102, 1'b0});
    vecs.push_back('{1'b1, 8'h04, 1'b0, 1'b1, 1'b1, 16'h0304, 1'b1});
    vecs.push_back('{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 16'h0304, 1'b1});
    vecs.push_back('{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 16'h0304, 1'b1});
    vecs.push_back('{1'b1, 8'h55, 1'b0, 1'b1, 1'b0, 16'h0304, 1'b1});
    vecs.push_back('{1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 16'h0304, 1'b1});
    vecs.push_back('{1'b1, 8'h66, 1'b0, 1'b1, 1'b1, 16'h5566, 1'b1});
    vecs.push_back('{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 16'h5566, 1'b1});
    vecs.push_back('{1'b1, 8'h77, 1'b0, 1'b1, 1'b1, 16'h5566, 1'b1});
    vecs.push_back('{1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 16'h5566, 1'b1});
    vecs.push_back('{1'b1, 8'h88, 1'b1, 1'b1, 1'b1, 16'h7788, 1'b1});
    vecs.push_back('{1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 16'h7788, 1'b1});

    // Reset state
    #1;
    check_zero("reset");
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    model_reset();

`ifndef CMD_CHECKSUM_EN
    // Vector table: held rx_rdy levels, handshakes, overrun, set-beats-clear
    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].rdy, vecs[i].data, vecs[i].clr);
      check_b($sformatf("vec%0d.clr_rx_rdy", i), clr_rx_rdy, vecs[i].e_clr_rx);
      check_b($sformatf("vec%0d.cmd_rdy", i), cmd_rdy, vecs[i].e_rdy);
      check_w($sformatf("vec%0d.cmd", i), cmd, vecs[i].e_cmd);
      check_b($sformatf("vec%0d.overrun", i), overrun, vecs[i].e_ovr);
      check_b($sformatf("vec%0d.tmo_err", i), tmo_err, 1'b0);
      $display("vec%0d rdy=%b data=%h clr=%b -> cmd=%h cmd_rdy=%b ovr=%b", i,
               vecs[i].rdy, vecs[i].data, vecs[i].clr, cmd, cmd_rdy, overrun);
    end

    // Reset in the middle of a command
    step(1'b1, 8'hFF, 1'b0);
    step(1'b0, 8'h00, 1'b0);
    rst = 1'b1;
    #1;
    check_zero("midrst");
    model_reset();
    for (int i = 0; i < 3; i++) begin
      step(1'b0, 8'h00, 1'b0);
      check_zero("midrst_hold");
    end
    rst = 1'b0;
    step(1'b1, 8'h10, 1'b0);
    step(1'b0, 8'h00, 1'b0);
    step(1'b1, 8'h20, 1'b0);
    check_w("after_rst.cmd", cmd, 16'h1020);
    check_b("after_rst.cmd_rdy", cmd_rdy, 1'b1);
    check_b("after_rst.tmo_err", tmo_err, 1'b0);
    $display("reset mid-command then 10,20 -> cmd=%h", cmd);
    step(1'b0, 8'h00, 1'b1);

    // Timeout: single byte, then silence for 25 cycles
    step(1'b1, 8'h12, 1'b0);
    for (int k = 1; k <= 25; k++) begin
      step(1'b0, 8'h00, 1'b0);
      check_b($sformatf("tmo.k%0d", k), tmo_err, k == TB_TMO);
      check_b("tmo.cmd_rdy", cmd_rdy, 1'b0);
    end
    step(1'b1, 8'h34, 1'b0);
    step(1'b0, 8'h00, 1'b0);
    step(1'b1, 8'h56, 1'b0);
    check_w("tmo_then.cmd", cmd, 16'h3456);
    check_b("tmo_then.cmd_rdy", cmd_rdy, 1'b1);
    $display("timeout then 34,56 -> cmd=%h", cmd);
    step(1'b0, 8'h00, 1'b1);

    // Second byte on the expiry cycle completes the command
    step(1'b1, 8'h9A, 1'b0);
    for (int k = 1; k < TB_TMO; k++) begin
      step(1'b0, 8'h00, 1'b0);
      check_b("expiry.wait_tmo", tmo_err, 1'b0);
    end
    step(1'b1, 8'hBC, 1'b0);
    check_b("expiry.tmo_err", tmo_err, 1'b0);
    check_w("expiry.cmd", cmd, 16'h9ABC);
    check_b("expiry.cmd_rdy", cmd_rdy, 1'b1);
    step(1'b0, 8'h00, 1'b1);
    check_b("expiry.tmo_after", tmo_err, 1'b0);
    $display("byte on expiry cycle -> cmd=%h", cmd);

    // One cycle late: partial discarded, late byte starts a new command
    step(1'b1, 8'hDE, 1'b0);
    for (int k = 1; k <= TB_TMO; k++) begin
      step(1'b0, 8'h00, 1'b0);
      check_b($sformatf("late.k%0d", k), tmo_err, k == TB_TMO);
    end
    step(1'b1, 8'hEF, 1'b0);
    check_b("late.cmd_rdy", cmd_rdy, 1'b0);
    step(1'b0, 8'h00, 1'b0);
    step(1'b1, 8'h01, 1'b0);
    check_w("late.cmd", cmd, 16'hEF01);
    check_b("late.cmd_rdy2", cmd_rdy, 1'b1);
    $display("late byte after timeout, then 01 -> cmd=%h", cmd);
    step(1'b0, 8'h00, 1'b1);
`else
    // Checksum: good frame completes, bad frame pulses chk_err only
    step(1'b1, 8'h10, 1'b0); step(1'b0, 8'h00, 1'b0);
    step(1'b1, 8'h20, 1'b0); step(1'b0, 8'h00, 1'b0);
    step(1'b1, 8'h30, 1'b0);
    check_w("chk_ok.cmd", cmd, 16'h1020);
    check_b("chk_ok.cmd_rdy", cmd_rdy, 1'b1);
    check_b("chk_ok.chk_err", chk_err, 1'b0);
    step(1'b0, 8'h00, 1'b0);
    step(1'b1, 8'h10, 1'b0); step(1'b0, 8'h00, 1'b0);
    step(1'b1, 8'h20, 1'b0); step(1'b0, 8'h00, 1'b0);
    step(1'b1, 8'h31, 1'b0);
    check_b("chk_bad.chk_err", chk_err, 1'b1);
    check_b("chk_bad.cmd_rdy", cmd_rdy, 1'b1);
    check_w("chk_bad.cmd", cmd, 16'h1020);
    check_b("chk_bad.overrun", overrun, 1'b0);
    step(1'b0, 8'h00, 1'b0);
    check_b("chk_bad.pulse_end", chk_err, 1'b0);
    $display("checksum frames -> cmd=%h", cmd);
    step(1'b0, 8'h00, 1'b1);
`endif

    // Randomized traffic against the reference model
    begin
      int gap = 0;
      logic r;
      for (int n = 0; n < 3000; n++) begin
        if (gap > 0) begin
          r = 1'b0;
          gap--;
        end else begin
          r = 1'($urandom_range(0, 1));
          if ($urandom_range(0, 15) == 0) gap = $urandom_range(5, 30);
        end
        step(r, 8'($urandom), ($urandom_range(0, 7) == 0));
        cmp_model("rand");
        if (m_done) $display("rand cycle %0d: cmd=%h overrun=%b", n, m_cmd, m_ovr);
        if (m_tmo) $display("rand cycle %0d: timeout", n);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
